vec_regfile_bypass: RTL
=======================

Name: vec_regfile_bypass

Overview:
- Parametrised vector register file for the SIMD datapath: two synchronous read ports and one lane-masked write port.
- Adds behaviour the first-generation file lacks:
  - per-lane write mask;
  - write-to-read bypass;
  - optional hard-wired zero register;
  - a sequenced clear engine that zeroes all entries after reset or on request, with a ready flag.
- Sits between vector decode (read addresses) and vector ALU writeback.

Parameters:
- LANES, 16, number of lanes per vector register.
- LANE_W, 16, bits per lane; vector width VW = LANES*LANE_W (256 default).
- DEPTH, 8, number of vector registers (power of 2, >= 2).
- AW, $clog2(DEPTH), address width (derived, not overridden).
- ZERO_REG0, 0, when 1, register 0 always reads zero and writes to it are dropped.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr_req  input  1  request to zero all registers (sampled only in IDLE).
- rd_en  input  1  read strobe for both ports.
- raddr_a  input  AW  read address port A.
- raddr_b  input  AW  read address port B.
- rdata_a  output  VW  registered read data A.
- rdata_b  output  VW  registered read data B.
- rvalid  output  1  rdata_a/rdata_b updated by the previous cycle's read.
- wr_en  input  1  write strobe.
- waddr  input  AW  write address.
- wmask  input  LANES  per-lane write enable; lane i covers bits [i*LANE_W +: LANE_W].
- wdata  input  VW  write data.
- ready  output  1  high when the clear sequence is finished and the file accepts traffic.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rdata_a/rdata_b = 0, rvalid = 0, ready = 0.
  - FSM enters CLEAR, clear pointer = 0.
  - Storage array is not reset directly; the clear engine zeroes it.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes all-zero to entry[ptr], ptr increments. After the cycle that writes entry DEPTH-1, the state moves to IDLE and ready=1 on the next edge. Total is DEPTH cycles from reset release (8 default).
  - In CLEAR: rd_en, wr_en and clr_req are ignored, rvalid stays 0, rdata holds its value.
  - IDLE: clr_req=1 moves to CLEAR next edge, ready drops to 0 on that edge, ptr = 0.
  - rst_n asserted mid-CLEAR restarts the sequence from ptr 0.
- Read (IDLE only):
  - rd_en=1 at edge N: rdata_a/rdata_b load entry[raddr_a]/entry[raddr_b]; rvalid=1 after edge N. Latency is 1 cycle.
  - rd_en=0: rvalid=0 next edge and rdata holds its previous value.
- Write (IDLE only): wr_en=1 updates only the lanes with wmask[i]=1; other lanes are unchanged. wmask=0 means no change.
- Bypass: if wr_en=1, rd_en=1 and waddr==raddr_x in the same cycle, rdata_x returns the merged value (new data for masked lanes, old data for the rest). Each port bypasses independently; both ports may hit.
- clr_req with wr_en in the same IDLE cycle:
  - The write is dropped, and bypass is disabled for that cycle.
  - A read in that cycle is served with the old contents.
  - CLEAR starts next edge.
- ZERO_REG0=1: reads of address 0 return 0 (including the bypass path); writes to address 0 have no effect.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
- Reset release, defaults: ready=0 for 8 cycles, then 1. Reads of all 8 entries return 0 with rvalid=1 one cycle after rd_en.
- Masked write: write entry 3 with wdata=all 0xAAAA lanes, wmask=16'hFFFF; then write wdata=0x5555 lanes, wmask=16'h00F0. Read 3 -> lanes 4-7 = 0x5555, all other lanes = 0xAAAA.
- Bypass: entry 5 = all 0x1111. Same cycle: wr_en, waddr=5, wmask=16'h0001, wdata lane0=0xBEEF, rd_en, raddr_a=5, raddr_b=2. Next cycle rdata_a lane0=0xBEEF and other lanes 0x1111; rdata_b = entry 2 unchanged.
- clr_req in IDLE with a simultaneous write to entry 1: ready=0 for 8 cycles. Traffic during CLEAR is ignored (rvalid stays 0). Afterwards entry 1 and all other entries read 0.
- ZERO_REG0=1 build: write 0xFFFF lanes to address 0 with a same-cycle read of address 0 -> rdata=0; a later read also returns 0.
- rst_n pulsed low at cycle 4 of CLEAR -> outputs zero immediately. ready rises exactly 8 cycles after the second reset release.

Source files
------------

// File: rtl/vec_regfile_bypass.sv
// Vector register file: two registered read ports, one lane-masked write port
// with write-to-read bypass, optional hard-wired zero register and a clear engine.
module vec_regfile_bypass #(
  parameter  int LANES     = 16,
  parameter  int LANE_W    = 16,
  parameter  int DEPTH     = 8,
  parameter  int ZERO_REG0 = 0,
  localparam int AW        = $clog2(DEPTH),
  localparam int VW        = LANES * LANE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  input  logic             rd_en,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [VW-1:0]    rdata_a,
  output logic [VW-1:0]    rdata_b,
  output logic             rvalid,
  input  logic             wr_en,
  input  logic [AW-1:0]    waddr,
  input  logic [LANES-1:0] wmask,
  input  logic [VW-1:0]    wdata,
  output logic             ready
);

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam logic ZR = (ZERO_REG0 != 0);

  state_t          state, state_nxt;
  logic [AW-1:0]   ptr;
  logic [VW-1:0]   mem [DEPTH];
  logic [VW-1:0]   wr_val, rd_val_a, rd_val_b;
  logic            idle, we, rd_ok;

  function automatic logic [VW-1:0] lane_merge(input logic [VW-1:0]    old_v,
                                               input logic [VW-1:0]    new_v,
                                               input logic [LANES-1:0] m);
    lane_merge = old_v;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) lane_merge[i*LANE_W +: LANE_W] = new_v[i*LANE_W +: LANE_W];
    end
  endfunction

  assign idle  = (state == IDLE);
  // A clear request in the same cycle wins over the write and suppresses bypass.
  assign we    = idle && wr_en && !clr_req && !(ZR && (waddr == '0));
  assign rd_ok = idle && rd_en;

  assign wr_val   = lane_merge(mem[waddr], wdata, wmask);
  assign rd_val_a = (ZR && (raddr_a == '0)) ? '0 :
                    (we && (waddr == raddr_a)) ? wr_val : mem[raddr_a];
  assign rd_val_b = (ZR && (raddr_b == '0)) ? '0 :
                    (we && (waddr == raddr_b)) ? wr_val : mem[raddr_b];

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (ptr == AW'(DEPTH - 1)) state_nxt = IDLE;
      IDLE:    if (clr_req) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  // Control and output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      ptr     <= '0;
      ready   <= 1'b0;
      rvalid  <= 1'b0;
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      state  <= state_nxt;
      ready  <= (state_nxt == IDLE);
      ptr    <= (state == CLEAR) ? ptr + AW'(1) : '0;
      rvalid <= rd_ok;
      if (rd_ok) begin
        rdata_a <= rd_val_a;
        rdata_b <= rd_val_b;
      end
    end
  end

  // Storage is zeroed by the clear engine rather than by reset.
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[ptr] <= '0;
    else if (we)        mem[waddr] <= wr_val;
  end

endmodule
